// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer state encoding, slice width and
// nibble-count helper used by the sequential adder controller and its slice.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/carry_look_ahead_adder.sv
// 4-bit carry-look-ahead adder slice: all internal carries are formed
// directly from generate/propagate terms rather than rippling.
module carry_look_ahead_adder
    import arith_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Sequential wide adder: one shared 4-bit look-ahead slice processes the
// operands a nibble per cycle, LSB first, with the carry held in a flop.
module cla_seq_adder_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t             state;
    state_t             state_next;
    logic [IDXW-1:0]    idx;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               accept;
    logic               last;

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST_IDX);

    assign slice_a = a_reg[SLICE_W*idx +: SLICE_W];
    assign slice_b = b_reg[SLICE_W*idx +: SLICE_W];

    carry_look_ahead_adder u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Partial sum is built in acc so the visible sum only moves on entry to DONE.
    always_comb begin
        acc_next = acc;
        acc_next[SLICE_W*idx +: SLICE_W] = slice_sum;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        acc       <= '0;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    acc       <= acc_next;
                    carry_reg <= slice_cout;
                    idx       <= last ? '0 : idx + 1'b1;
                    // MSB operand bits XOR the MSB sum bit recover the carry into the MSB.
                    if (last) begin
                        sum_reg  <= acc_next;
                        cout_reg <= slice_cout;
                        ovf_reg  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1]
                                  ^ slice_sum[SLICE_W-1] ^ slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed and random self-checking bench for the sequential nibble adder
// (WIDTH=16) covering reset, latency, carry/overflow corners and handshakes.
module tb_cla_seq_adder_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid, bounded.
    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic runDirected(input string tag,
                               input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                               input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int lat;
        applyStimulus(av, bv, cv);
        waitResult(lat);
        checkOutput({tag, "_latency"}, lat, 32'd4);
        checkOutput({tag, "_sum"}, {16'b0, sum}, {16'b0, es});
        checkOutput({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
        checkOutput({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        tick();
        checkOutput({tag, "_out_valid_drop"}, {31'b0, out_valid}, 32'd0);
        checkOutput({tag, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    function automatic logic [17:0] refAdd(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] full;
        logic        v;
        full = {1'b0, x} + {1'b0, y} + {16'b0, c};
        v    = (x[15] == y[15]) && (full[15] != x[15]);
        return {v, full};
    endfunction

    initial begin
        int               lat;
        int               acc_cyc;
        int               prev_cyc;
        logic [WIDTH-1:0] ca;
        logic [WIDTH-1:0] cb;
        logic             cc;
        logic [17:0]      exp_r;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_sum", {16'b0, sum}, 32'd0);
        checkOutput("reset_cout", {31'b0, cout}, 32'd0);
        checkOutput("reset_ovf", {31'b0, ovf}, 32'd0);

        // Idle in_valid-free cycles must not start anything.
        tick();
        checkOutput("idle_busy", {31'b0, busy}, 32'd0);

        runDirected("carry_mid", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        runDirected("wrap_b1",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        runDirected("wrap_cin",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        runDirected("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        runDirected("neg_ovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: result held while out_ready is low; new operands ignored.
        out_ready = 1'b0;
        applyStimulus(16'h0F0F, 16'h0101, 1'b1);
        waitResult(lat);
        checkOutput("bp_latency", lat, 32'd4);
        a        = 16'hAAAA;
        b        = 16'h5555;
        cin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("bp_sum", {16'b0, sum}, 32'h1011);
            checkOutput("bp_cout", {31'b0, cout}, 32'd0);
            checkOutput("bp_ovf", {31'b0, ovf}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        checkOutput("bp_not_consumed", {31'b0, busy}, 32'd0);

        // Reset during the second RUN cycle discards the operation.
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_sum", {16'b0, sum}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("midrst_no_stale", {31'b0, out_valid}, 32'd0);
        end
        runDirected("post_rst", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

        // Back-to-back random operations with in_valid held high throughout.
        a        = 16'($urandom());
        b        = 16'($urandom());
        cin      = 1'($urandom());
        in_valid = 1'b1;
        prev_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            checkOutput("rand_in_ready", {31'b0, in_ready}, 32'd1);
            ca = a;
            cb = b;
            cc = cin;
            tick();
            acc_cyc = cyc;
            a   = 16'($urandom());
            b   = 16'($urandom());
            cin = 1'($urandom());
            waitResult(lat);
            exp_r = refAdd(ca, cb, cc);
            checkOutput("rand_sum", {16'b0, sum}, {16'b0, exp_r[15:0]});
            checkOutput("rand_cout", {31'b0, cout}, {31'b0, exp_r[16]});
            checkOutput("rand_ovf", {31'b0, ovf}, {31'b0, exp_r[17]});
            if (i > 0) checkOutput("rand_ii", acc_cyc - prev_cyc, 32'd6);
            prev_cyc = acc_cyc;
            tick();
        end
        in_valid = 1'b0;
        tick();
        checkOutput("final_idle", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
